// File: rtl/ahb_readonly_cache.sv
// Direct-mapped, read-only, one-word-per-line AHB-Lite cache.
// Hits complete with zero wait states. Misses issue one single-beat read
// downstream, fill the line, then complete upstream. Writes get an ERROR.
module ahb_readonly_cache #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              src_hready_resp,
    input  logic              src_hready,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              dst_hready_resp,
    input  logic              dst_hready,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);
    localparam int W_INDEX = $clog2(DEPTH);
    localparam int W_TAG   = W_ADDR - W_INDEX - 2;
    localparam logic [2:0] HSIZE_WORD = 3'($clog2(W_DATA / 8));
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_DATA, S_RESP, S_ERR1, S_ERR2
    } state_t;

    state_t             state_q, state_d, next_phase;
    logic [W_ADDR-1:0]  addr_q, addr_d;
    logic [3:0]         hprot_q, hprot_d;
    logic [W_DATA-1:0]  buf_q, buf_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               rd_valid_q, rd_valid_d;
    logic [W_TAG-1:0]   rd_tag_q;
    logic [W_DATA-1:0]  rd_data_q;

    logic [W_TAG-1:0]   tag_mem  [DEPTH];
    logic [W_DATA-1:0]  data_mem [DEPTH];

    logic               accept, hit, fill;
    logic [W_INDEX-1:0] src_index, fill_index;
    logic               unused_ok;

    assign src_index  = src_haddr[W_INDEX+1:2];
    assign fill_index = addr_q[W_INDEX+1:2];
    // Only accept an address phase while this slave is actually ready.
    assign accept     = src_hready & src_htrans[1] & src_hready_resp;
    assign hit        = rd_valid_q & (rd_tag_q == addr_q[W_ADDR-1:W_INDEX+2]);
    assign fill       = (state_q == S_MISS_DATA) & dst_hready & ~dst_hresp;

    // Downstream controls that never change: single-beat word reads only.
    assign dst_hwrite    = 1'b0;
    assign dst_hsize     = HSIZE_WORD;
    assign dst_hburst    = 3'b000;
    assign dst_hmastlock = 1'b0;
    assign dst_hwdata    = '0;
    assign dst_hprot     = hprot_q;

    // Every read is a full-word read; size/burst/lock/wdata do not matter.
    assign unused_ok = ^{src_hwdata, src_hsize, src_hburst, src_hmastlock,
                         dst_hready_resp, addr_q[1:0]};

    // Tag/data RAM: synchronous read on address-phase accept, write on fill.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_index]  <= addr_q[W_ADDR-1:W_INDEX+2];
            data_mem[fill_index] <= dst_hrdata;
        end
        if (accept) begin
            rd_tag_q  <= tag_mem[src_index];
            rd_data_q <= data_mem[src_index];
        end
    end

    // Control state and per-line valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            hprot_q    <= '0;
            buf_q      <= '0;
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hprot_q    <= hprot_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Bus outputs decoded from state (and hit while in the lookup cycle).
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
        src_hrdata      = '0;
        dst_htrans      = HTRANS_IDLE;
        dst_haddr       = '0;
        case (state_q)
            S_LOOKUP: begin
                if (hit) begin
                    src_hrdata = rd_data_q;
                end else begin
                    src_hready_resp = 1'b0;
                    dst_htrans      = HTRANS_NONSEQ;
                    dst_haddr       = {addr_q[W_ADDR-1:2], 2'b00};
                end
            end
            S_MISS_DATA: src_hready_resp = 1'b0;
            S_RESP:      src_hrdata = buf_q;
            S_ERR1: begin
                src_hready_resp = 1'b0;
                src_hresp       = 1'b1;
            end
            S_ERR2:      src_hresp = 1'b1;
            default: ;
        endcase
    end

    // Next state, address capture and line fill.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hprot_d    = hprot_q;
        buf_d      = buf_q;
        valid_d    = valid_q;
        rd_valid_d = rd_valid_q;
        next_phase = S_IDLE;
        if (accept) begin
            addr_d     = src_haddr;
            hprot_d    = src_hprot;
            rd_valid_d = valid_q[src_index];
            next_phase = src_hwrite ? S_ERR1 : S_LOOKUP;
        end
        if (fill) begin
            valid_d[fill_index] = 1'b1;
            buf_d               = dst_hrdata;
        end
        case (state_q)
            S_IDLE:   state_d = next_phase;
            S_LOOKUP: begin
                if (hit)             state_d = next_phase;
                else if (dst_hready) state_d = S_MISS_DATA;
            end
            S_MISS_DATA: begin
                if (dst_hready) state_d = dst_hresp ? S_ERR1 : S_RESP;
            end
            S_RESP:   state_d = next_phase;
            S_ERR1:   state_d = S_ERR2;
            S_ERR2:   state_d = next_phase;
            default:  state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ahb_readonly_cache.sv
// Directed + random bench for ahb_readonly_cache with a simple SRAM-like
// downstream slave whose contents are a fixed function of the word address.
module tb_ahb_readonly_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_hready_resp, src_hready, src_hresp, src_hwrite, src_hmastlock;
    logic [31:0] src_haddr, src_hwdata, src_hrdata;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize, src_hburst;
    logic [3:0]  src_hprot;
    logic        dst_hready_resp, dst_hready, dst_hresp, dst_hwrite, dst_hmastlock;
    logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_readonly_cache #(.W_ADDR(32), .W_DATA(32), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready_resp(src_hready_resp), .src_hready(src_hready), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .dst_hready_resp(dst_hready_resp), .dst_hready(dst_hready), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
    );

    // Single upstream slave: bus HREADY is the cache's own HREADYOUT.
    assign src_hready = src_hready_resp;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Downstream slave model: configurable wait states, optional error address.
    logic        dph;
    logic [31:0] daddr;
    int          wcnt;
    int          dst_ws = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    int          ntrans;
    assign dst_hready      = !dph || (wcnt == 0);
    assign dst_hready_resp = dst_hready;
    assign dst_hrdata      = dph ? memf(daddr) : 32'h0;
    assign dst_hresp       = dph && err_en && (daddr == err_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph    <= 1'b0;
            daddr  <= 32'h0;
            wcnt   <= 0;
            ntrans <= 0;
        end else if (dst_hready) begin
            dph   <= dst_htrans[1];
            daddr <= dst_haddr;
            wcnt  <= dst_ws;
            if (dst_htrans[1]) ntrans <= ntrans + 1;
        end else begin
            wcnt <= wcnt - 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stream of upstream transfers, pipelined back to back.
    logic [31:0] s_addr [8];
    logic        s_wr   [8];
    int          s_w    [8];
    logic        s_resp [8];

    task automatic run_stream(input int n, input int exp_dst, input string nm);
        int   acc = 0, fin = 0, w = 0, cyc = 0, pidx = 0, d0;
        logic pend = 1'b0, take, hr, lastresp = 1'b0;
        string bn;
        d0 = ntrans;
        src_htrans = 2'b10; src_haddr = s_addr[0]; src_hwrite = s_wr[0];
        while (fin < n && cyc < 200) begin
            hr = src_hready_resp;
            if (pend) begin
                if (hr) begin
                    bn = $sformatf("%s[%0d]", nm, pidx);
                    check({bn, ".waits"}, w, s_w[pidx]);
                    check({bn, ".hresp"}, {31'b0, src_hresp}, {31'b0, s_resp[pidx]});
                    if (w > 0) check({bn, ".wait_hresp"}, {31'b0, lastresp}, {31'b0, s_resp[pidx]});
                    if (!s_wr[pidx] && !s_resp[pidx])
                        check({bn, ".data"}, src_hrdata, memf(s_addr[pidx]));
                    pend = 1'b0; fin++; w = 0;
                end else begin
                    w++;
                    lastresp = src_hresp;
                end
            end
            take = hr && src_htrans[1];
            if (take) begin pend = 1'b1; pidx = acc; acc++; end
            @(posedge clk); #1;
            cyc++;
            if (take) begin
                if (acc < n) begin src_haddr = s_addr[acc]; src_hwrite = s_wr[acc]; end
                else begin src_htrans = 2'b00; src_hwrite = 1'b0; end
            end
        end
        if (fin < n) begin
            checks++; failures++;
            $display("FAIL %s.timeout: got %0d done expected %0d", nm, fin, n);
            src_htrans = 2'b00;
        end
        check({nm, ".dst_count"}, ntrans - d0, exp_dst);
    endtask

    task automatic one(input logic [31:0] a, input logic wr, input int w, input logic r,
                       input int nd, input string nm);
        s_addr[0] = a; s_wr[0] = wr; s_w[0] = w; s_resp[0] = r;
        run_stream(1, nd, nm);
    endtask

    // Random soak: half the cycles present a transfer, mostly reads.
    task automatic soak(input int ncyc);
        logic pend = 1'b0, pwr = 1'b0, hold = 1'b0, take, hr;
        logic [31:0] paddr = 32'h0;
        int w = 0;
        for (int c = 0; c < ncyc + 60; c++) begin
            if (c >= ncyc && !pend && !hold) break;
            dst_ws = $urandom_range(0, 2);
            if (!hold) begin
                if (c < ncyc && $urandom_range(0, 1) == 1) begin
                    src_htrans = 2'b10;
                    src_haddr  = $urandom_range(0, 2047);
                    src_hwrite = ($urandom_range(0, 7) == 0);
                end else begin
                    src_htrans = 2'b00; src_hwrite = 1'b0;
                end
            end
            hr = src_hready_resp;
            if (pend) begin
                if (hr) begin
                    if (pwr) check("soak.wr_hresp", {31'b0, src_hresp}, 32'h1);
                    else begin
                        check("soak.rd_hresp", {31'b0, src_hresp}, 32'h0);
                        check("soak.rd_data", src_hrdata, memf(paddr));
                    end
                    pend = 1'b0; w = 0;
                end else if (++w > 20) begin
                    checks++; failures++;
                    $display("FAIL soak.timeout: got %0d waits expected <=20", w);
                    pend = 1'b0; w = 0;
                end
            end
            take = hr && src_htrans[1];
            if (take) begin pend = 1'b1; paddr = src_haddr; pwr = src_hwrite; end
            @(posedge clk); #1;
            hold = src_htrans[1] && !take;
        end
        if (pend || hold) begin
            checks++; failures++;
            $display("FAIL soak.drain: got pending expected idle");
        end
        src_htrans = 2'b00; dst_ws = 0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        int          waits;
        logic        resp;
        int          ndst;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{32'h0000_0010, 1'b0, 2, 1'b0, 1};  // cold miss
        vecs[1]  = '{32'h0000_0010, 1'b0, 0, 1'b0, 0};  // hit
        vecs[2]  = '{32'h0000_0410, 1'b0, 2, 1'b0, 1};  // alias evicts
        vecs[3]  = '{32'h0000_0010, 1'b0, 2, 1'b0, 1};  // evicted, miss again
        vecs[4]  = '{32'h0000_0020, 1'b1, 1, 1'b1, 0};  // write -> error
        vecs[5]  = '{32'h0000_0020, 1'b0, 2, 1'b0, 1};
        vecs[6]  = '{32'h0000_0020, 1'b0, 0, 1'b0, 0};
        vecs[7]  = '{32'h0000_0013, 1'b0, 0, 1'b0, 0};  // offset ignored
        vecs[8]  = '{32'h0000_002B, 1'b0, 2, 1'b0, 1};  // aligned fetch
        vecs[9]  = '{32'h0000_07FC, 1'b0, 2, 1'b0, 1};  // top index
        vecs[10] = '{32'hFFFF_FFFC, 1'b0, 2, 1'b0, 1};  // max tag
        vecs[11] = '{32'h0000_07FC, 1'b0, 2, 1'b0, 1};
        vecs[12] = '{32'h0000_07FE, 1'b0, 0, 1'b0, 0};

        rst_n = 1'b0;
        src_htrans = 2'b00; src_haddr = 32'h0; src_hwrite = 1'b0; src_hsize = 3'd2;
        src_hburst = 3'd0; src_hprot = 4'h3; src_hmastlock = 1'b0; src_hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.hready_resp", {31'b0, src_hready_resp}, 32'h1);
        check("rst.hresp", {31'b0, src_hresp}, 32'h0);
        check("rst.hrdata", src_hrdata, 32'h0);
        check("rst.dst_htrans", {30'b0, dst_htrans}, 32'h0);
        check("rst.dst_haddr", dst_haddr, 32'h0);
        check("rst.dst_hsize", {29'b0, dst_hsize}, 32'h2);
        check("rst.dst_hburst", {29'b0, dst_hburst}, 32'h0);
        check("rst.dst_hwrite", {31'b0, dst_hwrite}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            one(vecs[i].addr, vecs[i].wr, vecs[i].waits, vecs[i].resp, vecs[i].ndst,
                $sformatf("vec%0d", i));

        // Pipelined 0x0, 0x4, 0x0: last one hits the line filled two beats earlier.
        s_addr[0] = 32'h0; s_wr[0] = 1'b0; s_w[0] = 2; s_resp[0] = 1'b0;
        s_addr[1] = 32'h4; s_wr[1] = 1'b0; s_w[1] = 2; s_resp[1] = 1'b0;
        s_addr[2] = 32'h0; s_wr[2] = 1'b0; s_w[2] = 0; s_resp[2] = 1'b0;
        run_stream(3, 2, "pipe");

        // Miss, then the same address accepted during the response cycle.
        s_addr[0] = 32'h40; s_wr[0] = 1'b0; s_w[0] = 2; s_resp[0] = 1'b0;
        s_addr[1] = 32'h40; s_wr[1] = 1'b0; s_w[1] = 0; s_resp[1] = 1'b0;
        run_stream(2, 1, "refill_hit");

        // Slow downstream: two extra wait states pass straight through.
        dst_ws = 2;
        one(32'h80, 1'b0, 4, 1'b0, 1, "dst_wait");
        dst_ws = 0;

        // Downstream error: upstream error, line must not be filled.
        err_en = 1'b1; err_addr = 32'h90;
        one(32'h90, 1'b0, 3, 1'b1, 1, "dst_err");
        err_en = 1'b0;
        one(32'h90, 1'b0, 2, 1'b0, 1, "after_err");
        one(32'h90, 1'b0, 0, 1'b0, 0, "after_err_hit");

        soak(10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
